// File: rtl/x25519_pkg.sv
// x25519_pkg: shared field constants, element type, FSM state encoding and
// reduction helper for the GF(2^255-19) projective-to-affine converter.
package x25519_pkg;

  typedef logic [255:0] fe_t;

  // p = 2^255 - 19 = 0x7fff...ffed
  localparam fe_t FIELD_P         = {1'b0, {250{1'b1}}, 5'b01101};
  // p - 2 = 0x7fff...ffeb, the Fermat inversion exponent
  localparam fe_t FIELD_P_MINUS_2 = {1'b0, {250{1'b1}}, 5'b01011};
  // 2p = 2^256 - 38 still fits in 256 bits
  localparam fe_t FIELD_2P        = {{250{1'b1}}, 6'b011010};

  // Cycles from multiplier start to done (256 iterations + 1 final cycle)
  localparam int unsigned MUL_LAT = 257;

  typedef enum logic [2:0] {
    IDLE,
    EXP,
    MULX,
    MULY,
    DONE
  } state_e;

  // Any 256-bit value is < 2p + 38 < 3p, so at most two subtractions
  // bring it into [0, p-1].
  function automatic fe_t fe_reduce(input fe_t v);
    fe_t res;
    if (v >= FIELD_2P) begin
      res = v - FIELD_2P;
    end else if (v >= FIELD_P) begin
      res = v - FIELD_P;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/proj_to_affine_if.sv
// proj_to_affine_if: handshake bundle for the projective-to-affine converter.
//   in_valid/in_ready  : input point handshake, x_in/y_in/z_in projective coords
//   out_valid/out_ready: output handshake, x_out/y_out affine coords, zero_z flag
// master drives the inputs and consumes results; slave is the converter.
interface proj_to_affine_if;
  import x25519_pkg::*;

  logic in_valid;
  logic in_ready;
  fe_t  x_in;
  fe_t  y_in;
  fe_t  z_in;
  logic out_valid;
  logic out_ready;
  fe_t  x_out;
  fe_t  y_out;
  logic zero_z;

  modport master (
    output in_valid, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, zero_z
  );

  modport slave (
    input  in_valid, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, zero_z
  );

endinterface

// File: rtl/modmul_serial.sv
// modmul_serial: iterative modular multiplier r = a*b mod (2^255-19).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse; a and b are sampled on that edge
//   a, b       : any 256-bit operands (values >= p are treated mod p)
//   done       : one-cycle pulse MUL_LAT cycles after the start cycle
//   r          : canonical result in [0, p-1], held until the next start
// MSB-first interleaved shift-add: r = 2r + a[i]*b, reduced every step.
module modmul_serial
  import x25519_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  fe_t  a,
  input  fe_t  b,
  output logic done,
  output fe_t  r
);

  fe_t        a_q, a_d;
  fe_t        b_q, b_d;
  fe_t        r_q, r_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  fe_t        b_red;

  // With r < p and addend < p the sum is < 3p, so subtracting 2p or p
  // restores r < p.
  function automatic fe_t dbl_add(input fe_t acc, input fe_t addend);
    logic [256:0] t;
    t = {acc, 1'b0} + {1'b0, addend};
    if (t >= {1'b0, FIELD_2P}) begin
      t = t - {1'b0, FIELD_2P};
    end else if (t >= {1'b0, FIELD_P}) begin
      t = t - {1'b0, FIELD_P};
    end
    return t[255:0];
  endfunction

  assign b_red = fe_reduce(b);

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      // The load edge doubles as the first iteration (r = 0, so 2r + a[255]*b
      // is just a[255]*b); 255 iterations remain.
      b_d    = b_red;
      r_d    = a[255] ? b_red : '0;
      a_d    = {a[254:0], 1'b0};
      cnt_d  = 8'd255;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q != 8'd0) begin
        r_d   = dbl_add(r_q, a_q[255] ? b_q : '0);
        a_d   = {a_q[254:0], 1'b0};
        cnt_d = cnt_q - 8'd1;
      end else begin
        // Final canonicalisation cycle
        r_d    = (r_q >= FIELD_P) ? (r_q - FIELD_P) : r_q;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign r    = r_q;

endmodule

// File: rtl/proj_to_affine.sv
// proj_to_affine: converts an Edwards point (X:Y:Z) over GF(2^255-19) to
// affine (X/Z, Y/Z). Z^-1 = Z^(p-2) by left-to-right square-and-multiply on
// one shared serial multiplier, then x = X*Z^-1 and y = Y*Z^-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of proj_to_affine_if (input and output handshakes,
//                coordinates, zero_z flag when Z = 0 mod p)
// One point in flight; in_ready is high only in IDLE.
module proj_to_affine
  import x25519_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  proj_to_affine_if.slave        bus
);

  state_e     state_q, state_d;
  fe_t        x_q, x_d;
  fe_t        y_q, y_d;
  fe_t        z_q, z_d;
  fe_t        acc_q, acc_d;
  logic [7:0] idx_q, idx_d;
  logic       sq_q, sq_d;       // 1: next EXP multiply is the squaring
  logic       start_q, start_d;
  fe_t        x_out_q, x_out_d;
  fe_t        y_out_q, y_out_d;
  logic       zero_z_q, zero_z_d;

  fe_t        mul_a, mul_b, mul_r;
  logic       mul_done;

  modmul_serial u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_q),
    .a     (mul_a),
    .b     (mul_b),
    .done  (mul_done),
    .r     (mul_r)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    sq_d     = sq_q;
    start_d  = 1'b0;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    zero_z_d = zero_z_q;
    mul_a    = acc_q;
    mul_b    = acc_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          x_d      = bus.x_in;
          y_d      = bus.y_in;
          z_d      = bus.z_in;
          // Exponent bit 254 is 1, so starting from acc = Z skips it.
          acc_d    = bus.z_in;
          idx_d    = 8'd253;
          sq_d     = 1'b1;
          zero_z_d = 1'b0;
          start_d  = 1'b1;
          state_d  = EXP;
        end
      end
      EXP: begin
        mul_b = sq_q ? acc_q : z_q;
        if (mul_done) begin
          acc_d   = mul_r;
          start_d = 1'b1;
          if (sq_q && FIELD_P_MINUS_2[idx_q]) begin
            sq_d = 1'b0;
          end else begin
            sq_d = 1'b1;
            if (idx_q == 8'd0) begin
              state_d = MULX;
            end else begin
              idx_d = idx_q - 8'd1;
            end
          end
        end
      end
      MULX: begin
        mul_a = x_q;
        if (mul_done) begin
          x_out_d = mul_r;
          start_d = 1'b1;
          state_d = MULY;
        end
      end
      MULY: begin
        mul_a = y_q;
        if (mul_done) begin
          y_out_d  = mul_r;
          zero_z_d = (acc_q == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      sq_q     <= 1'b0;
      start_q  <= 1'b0;
      x_out_q  <= '0;
      y_out_q  <= '0;
      zero_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      sq_q     <= sq_d;
      start_q  <= start_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      zero_z_q <= zero_z_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.x_out     = x_out_q;
  assign bus.y_out     = y_out_q;
  assign bus.zero_z    = zero_z_q;

endmodule

// File: doc/proj_to_affine.md
Name: proj_to_affine

Overview:
- Converts an Edwards-curve point on GF(p), p = 2^255-19, from projective (X:Y:Z) to affine (x, y) = (X/Z, Y/Z).
- Sits directly downstream of the point-doubling stage and consumes its x2/y2/z2 outputs.
- Computes Z^-1 as Z^(p-2) by sequential square-and-multiply, then performs two output multiplies.
- Uses one shared, iterative modular multiplier.

Parameters:
- MUL_LAT, 257, cycles from multiplier start to multiplier done; fixed by the sub-module and exposed for latency checks only.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  projective point offered
- in_ready  out  1  block idle and able to accept a point
- x_in  in  256  projective X, any 256-bit value
- y_in  in  256  projective Y, any 256-bit value
- z_in  in  256  projective Z, any 256-bit value
- out_valid  out  1  affine result available
- out_ready  in  1  consumer accepts result
- x_out  out  256  affine x, fully reduced to [0, p-1]
- y_out  out  256  affine y, fully reduced to [0, p-1]
- zero_z  out  1  Z ≡ 0 mod p; x_out = y_out = 0 in that case

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state IDLE; in_ready=1; out_valid=0; x_out=y_out=0; zero_z=0.
- Reset asserted mid-operation aborts the computation immediately; no out_valid follows.
- Input handshake:
  - A transfer occurs when in_valid && in_ready; call this cycle 0.
  - X, Y, Z are captured into registers at that edge.
  - in_ready is low from cycle 1 until the output transfer completes.
- States:
  - IDLE: wait for input transfer, then go to EXP.
  - EXP: acc starts as Z. Bit index i runs from 253 down to 0 of E = p-2 = 0x7fff…ffeb.
    - Each step: acc = acc·acc, then, if E[i]=1, acc = acc·Z.
    - E[4] = E[2] = 0; all other bits 253..0 are 1.
    - Total 254 squarings and 252 multiplies.
  - MULX: xr = X·acc.
  - MULY: yr = Y·acc.
  - DONE: out_valid=1. Outputs are held stable while out_ready=0. Return to IDLE on out_valid && out_ready; in_ready=1 on the following cycle.
- Multiplier sequencing:
  - Each multiply is issued with a one-cycle start pulse in the cycle after the previous done (or after capture for the first).
  - Every operation therefore costs MUL_LAT+1 cycles.
  - out_valid rises exactly 508·(MUL_LAT+1)+1 cycles after cycle 0, i.e. 131 065 cycles at the default.
- Arithmetic:
  - All multiplier operands are 256-bit. Values ≥ p are legal inputs and are treated mod p.
  - Every multiplier result is canonical (< p).
  - acc is held < p after every step.
- zero_z: set in DONE iff the final acc == 0. Fermat gives 0^(p-2) = 0, so x_out = y_out = 0 follow naturally; no special data path.
- No pipelining: one point in flight. in_valid while busy is ignored and not captured.
- out_ready held high in DONE completes the transfer in the first DONE cycle.

Decomposition:
- Package x25519_pkg:
  - FIELD_P = 2^255-19
  - FIELD_P_MINUS_2 exponent constant
  - typedef fe_t as logic [255:0]
  - FSM state enum {IDLE, EXP, MULX, MULY, DONE}
  - MUL_LAT constant
- Sub-module modmul_serial:
  - Ports: clk, rst_n, start, a, b, done, r.
  - MSB-first interleaved shift-add with conditional subtract of p.
  - 256 iterations plus 1 final canonicalisation cycle, giving a done pulse MUL_LAT cycles after start.
  - Separately testable.

Test Plan:
- X=9, Y=5, Z=1 -> x_out=9, y_out=5, zero_z=0; out_valid exactly 131 065 cycles after acceptance.
- X=2, Y=4, Z=2 -> x_out=1, y_out=2. Then X=1, Y=1, Z=2 -> x_out=y_out=(p+1)/2 = 0x3fff…fff7.
- Z=0, X=7, Y=7 -> x_out=y_out=0, zero_z=1. Repeat with Z=p (0x7fff…ffed) -> identical response.
- X=p+3, Y=p-1, Z=p+1 -> x_out=3, y_out=p-1 (reduction of non-canonical inputs).
- Backpressure and busy:
  - Hold out_ready=0 for 50 cycles in DONE -> outputs stable and out_valid held.
  - in_ready=0 for the whole computation.
  - A second in_valid pulse mid-operation is not captured.
  - in_ready=1 one cycle after the output transfer.
- Reset and multiplier unit test:
  - Deassert rst_n at cycle 60 000 of an operation -> in_ready=1, out_valid=0 immediately. A new point (9,5,1) then completes correctly.
  - modmul_serial standalone: (p-1)·(p-1) -> 1, with done at MUL_LAT.
